// File: rtl/u409_pkg.sv
// u409_pkg: shared FSM state type and default E-clock timing constants.
package u409_pkg;
    typedef enum logic [1:0] {IDLE, WAIT, ACTIVE, DONE} state_t;
    localparam int E_DIV   = 10;
    localparam int E_HIGH  = 4;
    localparam int E_SETUP = 2;
endpackage

// File: rtl/u409_phase_ctr.sv
// u409_phase_ctr: E phase counter with sync load and registered E/E_RISE/E_FALL decode.
module u409_phase_ctr import u409_pkg::*; #(
    parameter int DIV      = E_DIV,
    parameter int HIGH_CNT = E_HIGH,
    parameter int CW       = $clog2(DIV)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          sync,
    output logic [CW-1:0] cnt,
    output logic          wrap,
    output logic          clkcia,
    output logic          e_rise,
    output logic          e_fall
);
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);
    localparam logic [CW-1:0] RISE = CW'(DIV - HIGH_CNT);
    logic [CW-1:0] cnt_q, cnt_d;
    logic clkcia_q, clkcia_d, e_rise_q, e_rise_d, e_fall_q, e_fall_d;
    always_comb begin
        cnt_d    = (sync || cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        clkcia_d = cnt_d >= RISE;
        e_rise_d = cnt_d == RISE;
        // a fall strobe only marks a real high-to-low transition of E
        e_fall_d = cnt_d == '0 && clkcia_q;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            clkcia_q <= 1'b0;
            e_rise_q <= 1'b0;
            e_fall_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            clkcia_q <= clkcia_d;
            e_rise_q <= e_rise_d;
            e_fall_q <= e_fall_d;
        end
    end
    assign cnt    = cnt_q;
    assign wrap   = cnt_q == LAST;
    assign clkcia = clkcia_q;
    assign e_rise = e_rise_q;
    assign e_fall = e_fall_q;
endmodule

// File: rtl/u409_eclk_sync.sv
// u409_eclk_sync: programmable E/CIA clock with 6800-style VMA/ACK access handshake.
module u409_eclk_sync import u409_pkg::*; #(
    parameter int DIV      = E_DIV,
    parameter int HIGH_CNT = E_HIGH,
    parameter int SETUP    = E_SETUP,
    parameter int CW       = $clog2(DIV)
) (
    input  logic CLK7,
    input  logic RESETn,
    input  logic SYNC,
    input  logic REQ,
    output logic CLKCIA,
    output logic E_RISE,
    output logic E_FALL,
    output logic VMA,
    output logic ACK
);
    localparam logic [CW-1:0] SP = CW'(DIV - HIGH_CNT - SETUP);
    if (DIV < 4 || DIV > 16 || HIGH_CNT < 1 || HIGH_CNT >= DIV ||
        SETUP < 1 || SETUP > DIV - HIGH_CNT) begin : g_bad_params
        $error("u409_eclk_sync: illegal DIV/HIGH_CNT/SETUP combination");
    end
    state_t state_q, state_d;
    logic vma_q, vma_d, ack_q, ack_d, drop_q, drop_d;
    logic [CW-1:0] cnt;
    logic wrap, sync_en, hit;
    assign sync_en = SYNC && state_q == IDLE;
    assign hit     = REQ && cnt == SP;
    u409_phase_ctr #(.DIV(DIV), .HIGH_CNT(HIGH_CNT), .CW(CW)) u_ctr (
        .clk(CLK7), .rst_n(RESETn), .sync(sync_en), .cnt(cnt), .wrap(wrap),
        .clkcia(CLKCIA), .e_rise(E_RISE), .e_fall(E_FALL)
    );
    always_comb begin
        state_d = state_q;
        vma_d   = vma_q;
        ack_d   = 1'b0;
        drop_d  = drop_q;
        case (state_q)
            IDLE, WAIT: begin
                state_d = hit ? ACTIVE : REQ ? WAIT : IDLE;
                vma_d   = hit;
                drop_d  = 1'b0;
            end
            ACTIVE: begin
                // a dropped request still runs the cycle out, only the ACK is withheld
                drop_d = drop_q || !REQ;
                if (wrap) begin
                    ack_d   = !drop_d;
                    vma_d   = 1'b0;
                    state_d = drop_d ? IDLE : DONE;
                end
            end
            DONE:    state_d = REQ ? DONE : IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge CLK7 or negedge RESETn) begin
        if (!RESETn) begin
            state_q <= IDLE;
            vma_q   <= 1'b0;
            ack_q   <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            vma_q   <= vma_d;
            ack_q   <= ack_d;
            drop_q  <= drop_d;
        end
    end
    assign VMA = vma_q;
    assign ACK = ack_q;
endmodule

// File: tb/tb_u409_eclk_sync.sv
// tb_u409_eclk_sync: directed scoreboard bench for the default and a DIV=6 instance.
module tb_u409_eclk_sync;
    typedef struct {logic [4:0] v; int cy;} exp_t;
    logic CLK7 = 1'b0;
    always #5 CLK7 = ~CLK7;
    logic rstn0, sync0, req0, e0, r0, f0, v0, a0;
    logic rstn1, sync1, req1, e1, r1, f1, v1, a1;
    u409_eclk_sync d0 (
        .CLK7(CLK7), .RESETn(rstn0), .SYNC(sync0), .REQ(req0),
        .CLKCIA(e0), .E_RISE(r0), .E_FALL(f0), .VMA(v0), .ACK(a0)
    );
    u409_eclk_sync #(.DIV(6), .HIGH_CNT(3), .SETUP(1)) d1 (
        .CLK7(CLK7), .RESETn(rstn1), .SYNC(sync1), .REQ(req1),
        .CLKCIA(e1), .E_RISE(r1), .E_FALL(f1), .VMA(v1), .ACK(a1)
    );
    exp_t q[$];
    int nchk = 0, npass = 0;
    int ecnt = 0, dv = 10, hi = 4, sp = 4, cy = 0;
    int vs = -100, ve = -100, ta = -100;
    logic sel = 1'b0;
    always @(negedge CLK7) begin : mon
        exp_t e;
        logic [4:0] o;
        if (q.size() > 0) begin
            e = q.pop_front();
            o = sel ? {e1, r1, f1, v1, a1} : {e0, r0, f0, v0, a0};
            nchk++;
            assert (o === e.v) npass++;
            else $error("FAIL dut%0d cyc%0d {E,RISE,FALL,VMA,ACK} got %b want %b", sel, e.cy, o, e.v);
        end
    end
    task automatic push(input logic [4:0] v);
        exp_t e;
        e.v = v;
        e.cy = cy;
        q.push_back(e);
    endtask
    task automatic cyc(input logic s, input logic r);
        logic ph;
        if (sel) begin sync1 = s; req1 = r; end
        else begin sync0 = s; req0 = r; end
        @(posedge CLK7);
        cy++;
        ph = ecnt >= dv - hi;
        ecnt = (s && !(vs < cy && cy <= ve)) ? 0 : (ecnt == dv - 1) ? 0 : ecnt + 1;
        push({ecnt >= dv - hi, ecnt == dv - hi, ecnt == 0 && ph, cy >= vs && cy < ve, cy == ta});
        @(negedge CLK7);
        #1;
    endtask
    task automatic rcyc();
        @(posedge CLK7);
        cy++;
        ecnt = 0;
        push(5'b0);
        @(negedge CLK7);
        #1;
    endtask
    task automatic idle_to(input int c);
        while (ecnt != c) cyc(1'b0, 1'b0);
    endtask
    // predicts the VMA window and ACK for a request first sampled on the next edge
    task automatic plan();
        vs = cy + 1 + (sp - ecnt + dv) % dv;
        ve = vs + dv - 1 - sp;
        ta = ve;
    endtask
    initial begin
        rstn0 = 1'b0; sync0 = 1'b0; req0 = 1'b0;
        rstn1 = 1'b0; sync1 = 1'b0; req1 = 1'b0;
        repeat (5) rcyc();
        rstn0 = 1'b1;
        repeat (40) cyc(1'b0, 1'b0);
        idle_to(2); plan();
        while (cy < ta) cyc(1'b0, 1'b1);
        repeat (12) cyc(1'b0, 1'b0);
        idle_to(5); plan();
        while (cy < ta) cyc(1'b0, 1'b1);
        repeat (3) cyc(1'b0, 1'b0);
        idle_to(0); plan();
        repeat (40) cyc(1'b0, 1'b1);
        repeat (3) cyc(1'b0, 1'b0);
        idle_to(4); plan(); ta = -1;
        while (ecnt != 7) cyc(1'b0, 1'b1);
        repeat (12) cyc(1'b0, 1'b0);
        idle_to(6); vs = -100; ve = -100; ta = -100;
        repeat (3) cyc(1'b0, 1'b1);
        repeat (12) cyc(1'b0, 1'b0);
        idle_to(3); cyc(1'b1, 1'b0);
        repeat (12) cyc(1'b0, 1'b0);
        idle_to(7); cyc(1'b1, 1'b0);
        repeat (4) cyc(1'b0, 1'b0);
        idle_to(2); plan();
        while (cy < ta) cyc(cy == vs + 1, 1'b1);
        repeat (3) cyc(1'b0, 1'b0);
        idle_to(4); vs = cy + 1; ve = vs + dv; ta = ve;
        cyc(1'b1, 1'b1);
        while (cy < ta) cyc(1'b0, 1'b1);
        repeat (3) cyc(1'b0, 1'b0);
        sel = 1'b1; dv = 6; hi = 3; sp = 2; ecnt = 0;
        repeat (2) rcyc();
        rstn1 = 1'b1;
        repeat (12) cyc(1'b0, 1'b0);
        idle_to(0); plan();
        while (cy < ta) cyc(1'b0, 1'b1);
        repeat (3) cyc(1'b0, 1'b0);
        idle_to(1); plan(); ta = -1;
        while (cy < vs + 1) cyc(1'b0, 1'b1);
        req1 = 1'b0;
        rstn1 = 1'b0;
        #1;
        nchk++;
        assert ({e1, r1, f1, v1, a1} === 5'b0) npass++;
        else $error("FAIL async_reset_mid_active got %b want %b", {e1, r1, f1, v1, a1}, 5'b0);
        vs = -100; ve = -100;
        repeat (2) rcyc();
        rstn1 = 1'b1;
        repeat (8) cyc(1'b0, 1'b0);
        @(posedge CLK7);
        #1;
        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end
endmodule
